// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one synchronous single-port memory between the fetch and
//            load/store requesters, with round-robin tie-break and wait states.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              gnt_d
);

    localparam int c_cnt_w = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_we;
    logic               w_pick_d;

    // On a tie the requester that did not own the last grant wins.
    assign w_pick_d = d_req && (!i_req || !gnt_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            busy    <= 1'b0;
            gnt_d   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req || d_req) begin
                        gnt_d   <= w_pick_d;
                        r_we    <= w_pick_d & d_we;
                        m_en    <= 1'b1;
                        m_we    <= w_pick_d & d_we;
                        m_addr  <= w_pick_d ? d_addr : i_addr;
                        m_wdata <= w_pick_d ? d_wdata : '0;
                        busy    <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_en    <= 1'b0;
                    m_we    <= 1'b0;
                    r_cnt   <= c_cnt_w'(LATENCY - 1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        if (!gnt_d) begin
                            i_rdata <= m_rdata;
                            i_ack   <= 1'b1;
                        end else begin
                            // A write leaves the load-data register untouched.
                            if (!r_we) begin
                                d_rdata <= m_rdata;
                            end
                            d_ack <= 1'b1;
                        end
                        r_state <= ACK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ACK: begin
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter for the single-cycle core. It shares one synchronous single-port memory between the instruction-fetch requester and the load/store requester. Requests use a req/ack handshake. Ties are resolved round-robin, and a wait-state counter absorbs the memory's read latency. It sits between the core's fetch/data bus and the memory macro, and is the block that stalls the core when fetch and data access collide.

## Interface
Parameters:
- ADDR_W, 32, address width for both requesters and memory
- DATA_W, 32, data width
- LATENCY, 1, memory read latency in cycles from m_en to valid m_rdata; legal range 1..8

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request; held high until i_ack
- i_addr  in  ADDR_W  fetch address; stable while i_req high
- i_rdata  out  DATA_W  fetch data; valid in the i_ack cycle, held until the next i_ack
- i_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req high
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  load data; valid in the d_ack cycle of a read, held otherwise
- d_ack  out  1  one-cycle data completion pulse
- m_en  out  1  memory access strobe, exactly one cycle per transaction
- m_we  out  1  memory write enable, qualified by m_en
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid LATENCY cycles after the m_en cycle
- busy  out  1  high in any state other than IDLE
- gnt_d  out  1  owner of the current or most recent grant: 1 = data, 0 = fetch

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not gnt_d's current value (round-robin). On a grant, latch the owner into gnt_d and go to ISSUE.
- ISSUE (1 cycle):
  - m_en = 1; m_addr, m_we and m_wdata come from the granted requester. Fetch is always a read; m_wdata = 0 for fetch.
  - Load the counter with LATENCY-1, then go to WAIT.
- WAIT:
  - m_en = m_we = 0; m_addr and m_wdata hold their values.
  - Decrement the counter each cycle. When the counter is 0, capture m_rdata into the owner's rdata register and go to ACK. For a data write, skip the capture so d_rdata holds.
- ACK (1 cycle):
  - Pulse the owner's ack, then go to IDLE. req is not sampled in this state.
- Writes take the same path and timing as reads, so every transaction is uniform.
- Requester protocol violations (req dropped, or addr/data changed before ack) are undefined for the memory contents. The FSM still finishes the transaction and still pulses ack.
- At most one ack is high in any cycle. i_ack and d_ack are never high together.

## Timing
- Numbering: cycle 0 is the cycle in which req is sampled high in IDLE. Then:
  - m_en is high in cycle 1.
  - m_rdata is captured at the end of cycle LATENCY+1.
  - ack is high in cycle LATENCY+2.
- A requester that holds req continuously is serviced every LATENCY+3 cycles.
- Under contention the two requesters strictly alternate. Neither waits more than one other transaction.
- Reset values:
  - state = IDLE, counter = 0.
  - m_en, m_we, m_addr, m_wdata = 0.
  - i_ack, d_ack = 0; i_rdata, d_rdata = 0.
  - busy = 0.
  - gnt_d = 1, so fetch wins the first tie.
- Reset asserted mid-transaction aborts it immediately, with no ack. A req still high after rst_n deasserts is treated as a new request.

## Test plan
- LATENCY=1, fetch i_addr=0x10, memory returns 0xDEADBEEF → m_en=1 with m_addr=0x10 in cycle 1; i_ack=1 with i_rdata=0xDEADBEEF in cycle 3; busy high in cycles 1-3.
- Both reqs high in the first cycle after reset → fetch granted first (gnt_d=0), data next (gnt_d=1), then alternating; i_ack and d_ack never high together.
- Data write d_addr=0x20, d_wdata=0x12345678 → m_en=m_we=1 in cycle 1 with that address and data; d_ack in cycle 3; d_rdata keeps its previous value.
- LATENCY=4 load → m_en in cycle 1, data captured at the end of cycle 5, d_ack in cycle 6.
- rst_n pulled low during WAIT → all outputs return to their reset values asynchronously; no ack; after release, the held req restarts from IDLE.
- i_req held high continuously with LATENCY=2 → i_ack pulses every 5 cycles; m_en only in the ISSUE cycles.
